dl_rshift_arb: RTL and testbench
================================

Name: dl_rshift_arb

Overview:
- Round-robin arbiter and sequencer that shares one dl_rshift instance among NUM_REQ requesters.
- Each requester presents an operand, a shift amount and a shift type on a valid/ready interface.
- Results return on a single registered response channel, tagged with the requester ID.
- Sits between the integer pipeline's shift-issuing clients (e.g. ALU, CSR/debug path) and the shared shifter datapath.

Parameters:
- NUM_BITS, 8, operand/result width; passed to dl_rshift.
- NUM_REQ, 4, number of requesters; must be >= 2.
- SHAMT_BITS, $clog2(NUM_BITS), shift-amount width (derived; not overridden).
- ID_BITS, $clog2(NUM_REQ), response tag width (derived).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_val  input  NUM_REQ  per-requester request valid.
- req_rdy  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_in  input  NUM_REQ*NUM_BITS  packed operands; requester i occupies [i*NUM_BITS +: NUM_BITS].
- req_shamt  input  NUM_REQ*SHAMT_BITS  packed shift amounts, same packing scheme.
- req_sh_type  input  NUM_REQ  per-requester type; 0 = logical, 1 = arithmetic.
- resp_val  output  1  response valid.
- resp_rdy  input  1  downstream accept.
- resp_out  output  NUM_BITS  shifted result.
- resp_id  output  ID_BITS  index of the requester that produced resp_out.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - resp_val=0, resp_out=0, resp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_rdy=0 combinationally whenever rst_n=0.
  - Reset mid-operation discards any held response; no handshake completes in the reset cycle.
- Output register state: EMPTY (resp_val=0) or FULL (resp_val=1).
  - can_accept = !resp_val || resp_rdy.
- Arbitration (combinational):
  - Winner = first i with req_val[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_rdy[winner] = can_accept; all other req_rdy bits = 0.
  - If no req_val is set, req_rdy = 0.
  - req_rdy does not depend on non-winning requesters' inputs.
- Transfer: a request fires when req_val[w] && req_rdy[w].
  - Winner's fields are muxed into the single dl_rshift.
  - Result is registered: resp_out <= shifter out, resp_id <= w, resp_val <= 1.
  - Latency: exactly 1 cycle from the accepting edge to resp_val=1.
- Pointer update:
  - On a fire, rr_ptr <= (w+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - With no fire, rr_ptr holds.
  - Any continuously-requesting client is served within NUM_REQ fires.
- Drain:
  - resp_val && resp_rdy with no new fire -> resp_val <= 0. resp_out/resp_id hold their last values.
  - Simultaneous drain and fire in the same cycle -> resp_val stays 1 and the register loads the new result. Back-to-back throughput is 1 per cycle.
- Backpressure:
  - FULL && !resp_rdy -> all req_rdy=0.
  - resp_out, resp_val and resp_id hold stable until accepted.
- Requester rules:
  - Once req_val is asserted, fields stay stable until it fires.
  - The arbiter does not latch unfired requests.
  - A requester may drop req_val without firing; that requester is simply skipped.
- Shift semantics (from dl_rshift):
  - logical: zero-fill.
  - arithmetic: fill with in[NUM_BITS-1].
  - shamt=0 -> result equals the operand.
  - shamt range 0..NUM_BITS-1; no overflow case exists.

Test Plan:
- Reset, single request: rst_n=0 for 2 cycles, then release; req_val=0001, in0=0x96, shamt0=3, type0=0, resp_rdy=1. Required: req_rdy=0001 that cycle, resp_val=1 next cycle, resp_out=0x12, resp_id=0.
- Arithmetic shift: same as above with type0=1. Required: resp_out=0xF2. Then in0=0x7F, shamt0=7, type0=1. Required: resp_out=0x00.
- Round-robin fairness: req_val=1111 held with resp_rdy=1. Required: grant order 0,1,2,3,0,1; resp_id follows the same sequence one cycle later; resp_val=1 every cycle after the first fire.
- Backpressure: output FULL with resp_out=0x12, resp_rdy=0 for 3 cycles while req_val=0110. Required: req_rdy=0000, resp_out/resp_id stable. Raise resp_rdy. Required: requester 1 fires in the same cycle the old response drains.
- Pointer wrap and skip: rr_ptr=3, req_val=1001. Required: grant 3 first, rr_ptr->0, then grant 0, rr_ptr->1. Drop req_val to 0000. Required: rr_ptr holds at 1, resp_val clears after drain.
- Reset mid-operation: resp_val=1, resp_rdy=0, assert rst_n=0 for one edge. Required: resp_val=0, resp_out=0, rr_ptr=0, no fire that cycle; normal arbitration resumes from requester 0.

Source files
------------

// File: rtl/dl_rshift_arb.sv
// Round-robin arbiter that time-shares one right shifter among NUM_REQ
// valid/ready requesters and returns tagged results on one registered channel.

module dl_rshift #(
  parameter  int NUM_BITS   = 8,
  localparam int SHAMT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]   in,
  input  logic [SHAMT_BITS-1:0] shamt,
  input  logic                  sh_type,
  output logic [NUM_BITS-1:0]   out
);

  // Logical (zero-fill) or arithmetic (sign-fill) right shift.
  always_comb begin
    if (sh_type) begin
      out = NUM_BITS'($signed(in) >>> shamt);
    end else begin
      out = in >> shamt;
    end
  end

endmodule

module dl_rshift_arb #(
  parameter  int NUM_BITS   = 8,
  parameter  int NUM_REQ    = 4,
  localparam int SHAMT_BITS = $clog2(NUM_BITS),
  localparam int ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_val,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*NUM_BITS-1:0]   req_in,
  input  logic [NUM_REQ*SHAMT_BITS-1:0] req_shamt,
  input  logic [NUM_REQ-1:0]            req_sh_type,
  output logic                          resp_val,
  input  logic                          resp_rdy,
  output logic [NUM_BITS-1:0]           resp_out,
  output logic [ID_BITS-1:0]            resp_id
);

  logic [ID_BITS-1:0]    r_rr_ptr;
  logic                  r_resp_val;
  logic [NUM_BITS-1:0]   r_resp_out;
  logic [ID_BITS-1:0]    r_resp_id;

  logic                  w_found;
  logic [ID_BITS-1:0]    w_win;
  logic                  w_can_accept;
  logic                  w_fire;
  logic [ID_BITS-1:0]    w_next_ptr;
  logic [NUM_BITS-1:0]   w_sh_in;
  logic [SHAMT_BITS-1:0] w_sh_amt;
  logic                  w_sh_type;
  logic [NUM_BITS-1:0]   w_sh_out;

  assign w_can_accept = !r_resp_val || resp_rdy;

  // Winner search starting at the round-robin pointer; the downward scan
  // lets the nearest requester after the pointer overwrite farther ones.
  always_comb begin
    int                 sum;
    logic [ID_BITS-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    sum     = 0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum     = int'(r_rr_ptr) + k;
      idx     = ID_BITS'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      w_win   = req_val[idx] ? idx : w_win;
      w_found = w_found | req_val[idx];
    end
  end

  assign w_fire     = rst_n && w_found && w_can_accept;
  assign req_rdy    = w_fire ? (NUM_REQ'(1) << w_win) : '0;
  assign w_next_ptr = (w_win == ID_BITS'(NUM_REQ - 1)) ? '0 : (w_win + ID_BITS'(1));

  assign w_sh_in   = req_in[int'(w_win)*NUM_BITS +: NUM_BITS];
  assign w_sh_amt  = req_shamt[int'(w_win)*SHAMT_BITS +: SHAMT_BITS];
  assign w_sh_type = req_sh_type[w_win];

  dl_rshift #(
    .NUM_BITS (NUM_BITS)
  ) u_shift (
    .in      (w_sh_in),
    .shamt   (w_sh_amt),
    .sh_type (w_sh_type),
    .out     (w_sh_out)
  );

  // Pointer and response register: a fire loads (even while draining),
  // a drain without fire only clears valid so data/id hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_resp_val <= 1'b0;
      r_resp_out <= '0;
      r_resp_id  <= '0;
    end else if (w_fire) begin
      r_rr_ptr   <= w_next_ptr;
      r_resp_val <= 1'b1;
      r_resp_out <= w_sh_out;
      r_resp_id  <= w_win;
    end else if (r_resp_val && resp_rdy) begin
      r_resp_val <= 1'b0;
    end
  end

  assign resp_val = r_resp_val;
  assign resp_out = r_resp_out;
  assign resp_id  = r_resp_id;

endmodule

// File: tb/tb_dl_rshift_arb.sv
// Scoreboard bench for dl_rshift_arb: directed scenarios plus randomized
// traffic checked against an arithmetic reference model.

module tb_dl_rshift_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_val;
  logic [3:0]  req_rdy;
  logic [31:0] req_in;
  logic [11:0] req_shamt;
  logic [3:0]  req_sh_type;
  logic        resp_val;
  logic        resp_rdy;
  logic [7:0]  resp_out;
  logic [1:0]  resp_id;

  dl_rshift_arb #(.NUM_BITS(8), .NUM_REQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_in      (req_in),
    .req_shamt   (req_shamt),
    .req_sh_type (req_sh_type),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_out    (resp_out),
    .resp_id     (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] q[$];
  logic       pend     = 1'b0;
  logic [9:0] pend_item;
  logic       rst_pend = 1'b0;
  logic       mon_en   = 1'b0;
  int         m_ptr    = 0;

  logic [7:0] a_in [4];
  logic [2:0] a_sh [4];
  logic       a_ty [4];
  logic       f_d;
  int         w_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference shift from plain arithmetic: division by 2^sh, floored for negatives.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input int sh, input logic ar);
    int x;
    int p;
    p = 1 << sh;
    x = int'(v);
    if (ar && x >= 128) begin
      x = x - 256;
      x = -((-x + p - 1) / p);
    end else begin
      x = x / p;
    end
    return x[7:0];
  endfunction

  // One clock cycle: settle the previous edge's scoreboard effect, drive, predict and check req_rdy.
  task automatic cycle(input logic rstv, input logic [3:0] val, input logic rdy,
                       output logic fired, output int fw);
    logic [3:0] exp_rdy;
    logic       can;
    int         idx;
    @(posedge clk);
    if (rst_pend) begin
      q.delete();
      #1;
      chk("reset_resp_val", {31'd0, resp_val}, 32'd0);
      chk("reset_resp_out", {24'd0, resp_out}, 32'd0);
      chk("reset_resp_id",  {30'd0, resp_id},  32'd0);
      mon_en = 1'b1;
    end else begin
      if (pend) q.push_back(pend_item);
      #1;
    end
    pend = 1'b0;
    rst_pend = 1'b0;
    #1;
    rst_n = rstv;
    req_val = val;
    resp_rdy = rdy;
    for (int i = 0; i < 4; i++) begin
      req_in[i*8 +: 8]    = a_in[i];
      req_shamt[i*3 +: 3] = a_sh[i];
      req_sh_type[i]      = a_ty[i];
    end
    #1;
    fired = 1'b0;
    fw = -1;
    exp_rdy = 4'b0000;
    if (rstv) begin
      can = (q.size() == 0) || rdy;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (fw < 0 && val[idx]) fw = idx;
      end
      if (fw >= 0 && can) begin
        fired = 1'b1;
        exp_rdy[fw] = 1'b1;
      end else begin
        fw = -1;
      end
    end
    chk("req_rdy", {28'd0, req_rdy}, {28'd0, exp_rdy});
    if (!rstv) begin
      rst_pend = 1'b1;
      m_ptr = 0;
    end else if (fired) begin
      pend = 1'b1;
      pend_item = {fw[1:0], ref_shift(a_in[fw], int'(a_sh[fw]), a_ty[fw])};
      m_ptr = (fw + 1) % 4;
    end
  endtask

  logic       prev_hold = 1'b0;
  logic       prev_rstn = 1'b0;
  logic [7:0] prev_out;
  logic [1:0] prev_id;
  logic [9:0] exp_item;

  // Monitor: handshake values are stable from here to the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("resp_val_vs_model", {31'd0, resp_val}, {31'd0, (q.size() != 0)});
      if (prev_hold && prev_rstn) begin
        chk("hold_out", {24'd0, resp_out}, {24'd0, prev_out});
        chk("hold_id",  {30'd0, resp_id},  {30'd0, prev_id});
      end
      if (rst_n && resp_val && resp_rdy && q.size() != 0) begin
        exp_item = q.pop_front();
        chk("resp_id",  {30'd0, resp_id},  {30'd0, exp_item[9:8]});
        chk("resp_out", {24'd0, resp_out}, {24'd0, exp_item[7:0]});
      end
      prev_hold = resp_val && !resp_rdy;
      prev_rstn = rst_n;
      prev_out  = resp_out;
      prev_id   = resp_id;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic       rdy;
    logic       rstv;
    rst_n = 1'b0;
    req_val = 4'b0000;
    resp_rdy = 1'b0;
    req_in = 32'd0;
    req_shamt = 12'd0;
    req_sh_type = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a_in[i] = 8'h00; a_sh[i] = 3'd0; a_ty[i] = 1'b0;
    end

    cycle(1'b0, 4'b0000, 1'b1, f_d, w_d);
    cycle(1'b0, 4'b0000, 1'b1, f_d, w_d);

    a_in[0] = 8'h96; a_sh[0] = 3'd3; a_ty[0] = 1'b0;
    cycle(1'b1, 4'b0001, 1'b1, f_d, w_d);
    cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    chk("tp_logical_out", {24'd0, resp_out}, 32'h12);
    chk("tp_logical_val", {31'd0, resp_val}, 32'd1);

    a_ty[0] = 1'b1;
    cycle(1'b1, 4'b0001, 1'b1, f_d, w_d);
    cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    chk("tp_arith_out", {24'd0, resp_out}, 32'hF2);
    a_in[0] = 8'h7F; a_sh[0] = 3'd7;
    cycle(1'b1, 4'b0001, 1'b1, f_d, w_d);
    cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    chk("tp_arith_7f", {24'd0, resp_out}, 32'h00);

    cycle(1'b0, 4'b0000, 1'b1, f_d, w_d);
    for (int i = 0; i < 4; i++) begin
      a_in[i] = 8'h81 + 8'(i * 37); a_sh[i] = 3'(i + 1); a_ty[i] = i[0];
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 4'b1111, 1'b1, f_d, w_d);
      chk("rr_order", w_d, k % 4);
    end

    a_in[0] = 8'h96; a_sh[0] = 3'd3; a_ty[0] = 1'b0;
    cycle(1'b1, 4'b0001, 1'b1, f_d, w_d);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0110, 1'b0, f_d, w_d);
    chk("bp_out_held", {24'd0, resp_out}, 32'h12);
    cycle(1'b1, 4'b0110, 1'b1, f_d, w_d);
    chk("bp_release_grant", w_d, 1);

    cycle(1'b1, 4'b0100, 1'b1, f_d, w_d);
    cycle(1'b1, 4'b1001, 1'b1, f_d, w_d);
    chk("wrap_grant3", w_d, 3);
    cycle(1'b1, 4'b1001, 1'b1, f_d, w_d);
    chk("wrap_grant0", w_d, 0);
    cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    chk("idle_drained", {31'd0, resp_val}, 32'd0);
    cycle(1'b1, 4'b0110, 1'b1, f_d, w_d);
    chk("ptr_held_grant1", w_d, 1);

    cycle(1'b1, 4'b0000, 1'b0, f_d, w_d);
    cycle(1'b0, 4'b0001, 1'b0, f_d, w_d);
    cycle(1'b1, 4'b0011, 1'b1, f_d, w_d);
    chk("post_reset_grant0", w_d, 0);

    v = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && $urandom_range(0, 99) < 5) begin
          v[i] = 1'b0;
        end else if (!v[i] && $urandom_range(0, 99) < 50) begin
          v[i] = 1'b1;
          a_in[i] = 8'($urandom);
          a_sh[i] = 3'($urandom_range(0, 7));
          a_ty[i] = 1'($urandom);
        end
      end
      rdy  = ($urandom_range(0, 99) < 70);
      rstv = ($urandom_range(0, 99) != 0);
      cycle(rstv, v, rdy, f_d, w_d);
      if (f_d) v[w_d] = 1'b0;
    end

    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0000, 1'b1, f_d, w_d);
    chk("final_queue_empty", q.size(), 0);
    chk("final_resp_val", {31'd0, resp_val}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
